// File: rtl/rot_sweep_pkg.sv
// Shared types and constants for the rotation sweep sequencer.
// Includes a reference nibble-sum helper.
package rot_sweep_pkg;

    localparam int NIB_W  = 4;
    localparam int DATA_W = 32;
    localparam int SUM_W  = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Sum of the low nibble over amounts 0..num_rot-1, right-rotating each step.
    function automatic logic [SUM_W-1:0] exp_nib_sum(
        input logic [NIB_W-1:0] nib,
        input int               num_rot
    );
        logic [NIB_W-1:0] n;
        logic [SUM_W-1:0] s;
        n = nib;
        s = '0;
        for (int k = 0; k < num_rot; k++) begin
            s = s + SUM_W'(n);
            n = {n[0], n[NIB_W-1:1]};
        end
        return s;
    endfunction

endpackage

// File: rtl/rot_sweep_seq_circular_shift.sv
// Combinational 4-bit circular right shift of the low nibble.
// Upper bits pass through unchanged.
import rot_sweep_pkg::*;

module circular_shift #(
    parameter int AMT_W = 5
) (
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  amt,
    output logic [DATA_W-1:0] result
);

    logic [NIB_W-1:0] nib;
    logic [NIB_W-1:0] rot;
    logic             unused_amt;

    assign nib        = data[NIB_W-1:0];
    assign unused_amt = ^amt[AMT_W-1:2];

    always_comb begin
        rot = nib;
        case (amt[1:0])
            2'd0: rot = nib;
            2'd1: rot = {nib[0], nib[3:1]};
            2'd2: rot = {nib[1:0], nib[3:2]};
            2'd3: rot = {nib[2:0], nib[3]};
            default: rot = nib;
        endcase
    end

    assign result = {data[DATA_W-1:NIB_W], rot};

endmodule

// File: rtl/rot_sweep_seq.sv
// Sequencer sweeping nibble rotation amounts over one held operand,
// emitting one registered beat per amount plus a running nibble sum.
import rot_sweep_pkg::*;

module rot_sweep_seq #(
    parameter int NUM_ROT = 4,
    parameter int AMT_W   = 5
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              clear_in,
    input  logic              in_valid_in,
    input  logic [DATA_W-1:0] in_data_in,
    output logic              in_ready_out,
    output logic              out_valid_out,
    input  logic              out_ready_in,
    output logic [DATA_W-1:0] out_data_out,
    output logic [AMT_W-1:0]  out_amt_out,
    output logic              out_last_out,
    output logic [SUM_W-1:0]  nib_sum_out
);

    state_t            state;
    logic [DATA_W-1:0] held;
    logic [AMT_W-1:0]  cnt;
    logic [AMT_W-1:0]  cnt_nx;
    logic              accept;
    logic              hs;
    logic [DATA_W-1:0] sh_in;
    logic [AMT_W-1:0]  sh_amt;
    logic [DATA_W-1:0] sh_out;

    assign hs           = out_valid_out & out_ready_in;
    assign in_ready_out = ~clear_in &
                          ((state == IDLE) | (hs & out_last_out));
    assign accept       = in_valid_in & in_ready_out;
    assign cnt_nx       = cnt + AMT_W'(1);

    // A fresh operand always starts at the identity amount.
    assign sh_in  = accept ? in_data_in : held;
    assign sh_amt = accept ? '0 : cnt_nx;

    circular_shift #(
        .AMT_W (AMT_W)
    ) u_shift (
        .data   (sh_in),
        .amt    (sh_amt),
        .result (sh_out)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n_in || clear_in) begin
            state         <= IDLE;
            held          <= '0;
            cnt           <= '0;
            out_valid_out <= 1'b0;
            out_data_out  <= '0;
            out_amt_out   <= '0;
            out_last_out  <= 1'b0;
            nib_sum_out   <= '0;
        end else if (accept) begin
            state         <= RUN;
            held          <= in_data_in;
            cnt           <= '0;
            out_valid_out <= 1'b1;
            out_data_out  <= sh_out;
            out_amt_out   <= '0;
            out_last_out  <= (NUM_ROT == 1);
            nib_sum_out   <= SUM_W'(in_data_in[NIB_W-1:0]);
        end else if (state == RUN && hs) begin
            if (!out_last_out) begin
                cnt          <= cnt_nx;
                out_data_out <= sh_out;
                out_amt_out  <= cnt_nx;
                out_last_out <= (cnt_nx == AMT_W'(NUM_ROT - 1));
                nib_sum_out  <= nib_sum_out + SUM_W'(sh_out[NIB_W-1:0]);
            end else begin
                state         <= IDLE;
                out_valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rot_sweep_seq.sv
// Directed bench for rot_sweep_seq with hand-computed beats.
// A second instance covers the single-beat build.
import rot_sweep_pkg::*;

module tb_rot_sweep_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_amt;
    logic        out_last;
    logic [5:0]  nib_sum;

    logic        in_valid1;
    logic [31:0] in_data1;
    logic        in_ready1;
    logic        out_valid1;
    logic        out_ready1;
    logic [31:0] out_data1;
    logic [4:0]  out_amt1;
    logic        out_last1;
    logic [5:0]  nib_sum1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rot_sweep_seq u_dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .clear_in      (clear),
        .in_valid_in   (in_valid),
        .in_data_in    (in_data),
        .in_ready_out  (in_ready),
        .out_valid_out (out_valid),
        .out_ready_in  (out_ready),
        .out_data_out  (out_data),
        .out_amt_out   (out_amt),
        .out_last_out  (out_last),
        .nib_sum_out   (nib_sum)
    );

    rot_sweep_seq #(
        .NUM_ROT (1)
    ) u_dut1 (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .clear_in      (clear),
        .in_valid_in   (in_valid1),
        .in_data_in    (in_data1),
        .in_ready_out  (in_ready1),
        .out_valid_out (out_valid1),
        .out_ready_in  (out_ready1),
        .out_data_out  (out_data1),
        .out_amt_out   (out_amt1),
        .out_last_out  (out_last1),
        .nib_sum_out   (nib_sum1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the presented beat, then let it handshake on the next edge.
    task automatic beat(input string tag, input logic [31:0] d,
                        input logic [4:0] a, input logic l,
                        input logic [5:0] s);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_amt"}, {27'd0, out_amt}, {27'd0, a});
        chk({tag, "_last"}, {31'd0, out_last}, {31'd0, l});
        chk({tag, "_sum"}, {26'd0, nib_sum}, {26'd0, s});
        tick();
    endtask

    task automatic send(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
    endtask

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        in_data1   = '0;
        out_ready1 = 1'b1;
        tick();
        tick();

        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_amt", {27'd0, out_amt}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_sum", {26'd0, nib_sum}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        chk("fn_sum", {26'd0, exp_nib_sum(4'h9, 4)}, 32'd30);

        // Plain sweep
        send(32'hA5A5_A5A9);
        beat("t1b0", 32'hA5A5_A5A9, 5'd0, 1'b0, 6'd9);
        beat("t1b1", 32'hA5A5_A5AC, 5'd1, 1'b0, 6'd21);
        beat("t1b2", 32'hA5A5_A5A6, 5'd2, 1'b0, 6'd27);
        beat("t1b3", 32'hA5A5_A5A3, 5'd3, 1'b1, 6'd30);
        chk("t1_idle", {31'd0, out_valid}, 32'd0);
        chk("t1_ready", {31'd0, in_ready}, 32'd1);

        // Stall on beat 1
        send(32'hA5A5_A5A9);
        beat("t2b0", 32'hA5A5_A5A9, 5'd0, 1'b0, 6'd9);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_st_valid", {31'd0, out_valid}, 32'd1);
            chk("t2_st_data", out_data, 32'hA5A5_A5AC);
            chk("t2_st_amt", {27'd0, out_amt}, 32'd1);
            chk("t2_st_sum", {26'd0, nib_sum}, 32'd21);
            tick();
        end
        out_ready = 1'b1;
        beat("t2b1", 32'hA5A5_A5AC, 5'd1, 1'b0, 6'd21);
        beat("t2b2", 32'hA5A5_A5A6, 5'd2, 1'b0, 6'd27);
        beat("t2b3", 32'hA5A5_A5A3, 5'd3, 1'b1, 6'd30);
        chk("t2_idle", {31'd0, out_valid}, 32'd0);

        // Back-to-back operands
        in_valid = 1'b1;
        in_data  = 32'h0000_000F;
        tick();
        in_data  = 32'h0000_0000;
        beat("t3a0", 32'h0000_000F, 5'd0, 1'b0, 6'd15);
        beat("t3a1", 32'h0000_000F, 5'd1, 1'b0, 6'd30);
        beat("t3a2", 32'h0000_000F, 5'd2, 1'b0, 6'd45);
        chk("t3_b2b_ready", {31'd0, in_ready}, 32'd1);
        beat("t3a3", 32'h0000_000F, 5'd3, 1'b1, 6'd60);
        in_valid = 1'b0;
        beat("t3b0", 32'h0000_0000, 5'd0, 1'b0, 6'd0);
        beat("t3b1", 32'h0000_0000, 5'd1, 1'b0, 6'd0);
        beat("t3b2", 32'h0000_0000, 5'd2, 1'b0, 6'd0);
        beat("t3b3", 32'h0000_0000, 5'd3, 1'b1, 6'd0);
        chk("t3_idle", {31'd0, out_valid}, 32'd0);

        // Clear mid-transaction
        send(32'h0000_0003);
        beat("t4b0", 32'h0000_0003, 5'd0, 1'b0, 6'd3);
        beat("t4b1", 32'h0000_0009, 5'd1, 1'b0, 6'd12);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0000_0007;
        #1;
        chk("t4_clr_ready", {31'd0, in_ready}, 32'd0);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t4_clr_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_clr_sum", {26'd0, nib_sum}, 32'd0);
        chk("t4_clr_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        chk("t4_no_accept", {31'd0, out_valid}, 32'd0);
        send(32'h0000_0001);
        beat("t4c0", 32'h0000_0001, 5'd0, 1'b0, 6'd1);
        beat("t4c1", 32'h0000_0008, 5'd1, 1'b0, 6'd9);
        beat("t4c2", 32'h0000_0004, 5'd2, 1'b0, 6'd13);
        beat("t4c3", 32'h0000_0002, 5'd3, 1'b1, 6'd15);

        // Reset mid-transaction
        send(32'h0000_0005);
        beat("t5b0", 32'h0000_0005, 5'd0, 1'b0, 6'd5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_data", out_data, 32'd0);
        chk("t5_amt", {27'd0, out_amt}, 32'd0);
        chk("t5_last", {31'd0, out_last}, 32'd0);
        chk("t5_sum", {26'd0, nib_sum}, 32'd0);
        tick();
        chk("t5_no_stale", {31'd0, out_valid}, 32'd0);
        chk("t5_ready", {31'd0, in_ready}, 32'd1);

        // Single-beat build
        chk("t6_ready", {31'd0, in_ready1}, 32'd1);
        in_valid1 = 1'b1;
        in_data1  = 32'h1234_5677;
        tick();
        in_valid1 = 1'b0;
        chk("t6_valid", {31'd0, out_valid1}, 32'd1);
        chk("t6_data", out_data1, 32'h1234_5677);
        chk("t6_amt", {27'd0, out_amt1}, 32'd0);
        chk("t6_last", {31'd0, out_last1}, 32'd1);
        chk("t6_sum", {26'd0, nib_sum1}, 32'd7);
        tick();
        chk("t6_idle", {31'd0, out_valid1}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rot_sweep_seq.md
Name: rot_sweep_seq

Overview:
- Upstream sequencer for the 4-bit circular-shift stage.
- Accepts one 32-bit operand word per transaction over valid/ready.
- Sweeps rotation amounts 0..NUM_ROT-1 through an internal circular-shift instance. Emits one registered rotated word per amount on a valid/ready output stream, tagged with amount and last flag.
- On the last beat, also reports the sum of the low nibbles of all emitted beats. Downstream CIM weight-staging logic uses this as an integrity check.

Parameters:
- NUM_ROT, 4, beats per transaction (rotation amounts 0..NUM_ROT-1); legal range 1..4.
- AMT_W, 5, width of rotation amount, matching the circular-shift stage.

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  reset; one clock; reset is synchronous and active-low
- clear_in  input  1  synchronous abort of current transaction
- in_valid_in  input  1  operand valid
- in_data_in  input  32  operand word
- in_ready_out  output  1  operand accepted when in_valid_in & in_ready_out
- out_valid_out  output  1  beat valid
- out_ready_in  input  1  downstream ready
- out_data_out  output  32  rotated word: bits[31:4] = operand[31:4]; bits[3:0] = operand[3:0] rotated by out_amt_out
- out_amt_out  output  AMT_W  rotation amount of this beat
- out_last_out  output  1  final beat of transaction
- nib_sum_out  output  6  running sum of out_data_out[3:0] over the transaction including this beat; meaningful when out_last_out=1

Behaviour:
- Reset values (rst_n_in low at a clock edge):
  - state=IDLE; out_valid_out=0; out_data_out=0; out_amt_out=0; out_last_out=0; nib_sum_out=0.
  - Held word and beat counter are cleared.
  - in_ready_out=1 from the first cycle after reset is released.
- States: IDLE, RUN.
- IDLE:
  - in_ready_out=1.
  - On accept: latch in_data_in; beat counter cnt=0.
  - At the same edge, load the output register with the amt-0 result (identity), out_amt_out=0, nib_sum_out=in_data_in[3:0], and out_last_out=(NUM_ROT==1).
  - Go to RUN. Latency: accept edge -> out_valid_out high the following cycle.
- RUN:
  - out_valid_out=1. The output register is held stable while out_ready_in=0; no field may change.
  - On a handshake with out_last_out=0: cnt+=1; load the rotation of the held word by cnt+1; nib_sum_out += new low nibble; out_last_out=(cnt+1==NUM_ROT-1).
  - On a handshake with out_last_out=1:
    - If in_valid_in=1, accept the next operand at the same edge (back-to-back). in_ready_out = (state==IDLE) | (out_valid_out & out_ready_in & out_last_out). Load its amt-0 beat; stay in RUN.
    - Otherwise, go to IDLE and drop out_valid_out the next cycle.
- Rotation: amount k rotates the low nibble right by k (bit[i] <- bit[(i+k) mod 4]). Amount 0 is identity; bits[31:4] always pass through unchanged.
- Width: nib_sum_out is 6 bits, max 4*15=60, so it cannot overflow. For NUM_ROT=4 the final sum always equals 15*popcount(operand[3:0]).
- clear_in:
  - Takes priority over all handshakes.
  - Next cycle: IDLE, out_valid_out=0, nib_sum_out=0.
  - An operand presented in the same cycle is not accepted (in_ready_out forced to 0 while clear_in=1).
- Reset mid-transaction: same as clear; beats not yet handshaken are lost, with no partial output after release.
- in_data_in is ignored whenever in_ready_out=0.

Decomposition:
- Shared package rot_sweep_pkg:
  - state enum (IDLE, RUN)
  - NIB_W=4, DATA_W=32, SUM_W=6 constants
  - function computing the expected nibble sum for benches
- Sub-module: the existing circular_shift block, a single combinational instance. Input is a mux of in_data_in (on accept) or the held word. Amount is 0 on accept, else cnt+1.

Test Plan:
- Operand 0xA5A5A5A9, out_ready_in=1 -> beats 0xA5A5A5A9/0, 0xA5A5A5AC/1, 0xA5A5A5A6/2, 0xA5A5A5A3/3 in consecutive cycles. out_last_out only on beat 3; nib_sum_out=30 there.
- Same operand, out_ready_in low 3 cycles on beat 1 -> out_data_out held 0xA5A5A5AC for all stall cycles; no beat skipped or duplicated; final sum 30.
- Back-to-back 0x0000000F then 0x00000000, in_valid_in held -> second accepted on the last-beat handshake. 8 beats with no bubble; sums 60 and 0.
- clear_in pulsed after beat 1 handshake -> out_valid_out=0 next cycle, in_ready_out=1. A new operand 0x1 then yields beats 1,8,4,2 with sum 15.
- rst_n_in low mid-RUN for 1 cycle -> all outputs at reset values next cycle; no stale beat after release.
- NUM_ROT=1 build, operand 0x12345677 -> single beat 0x12345677, out_last_out=1, nib_sum_out=7.
